// File: rtl/tick_sched_pkg.sv
// Shared encodings for the tick scheduler: controller states, command codes and config address map.
package tick_sched_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_START = 2'b01,
        CMD_PAUSE = 2'b10,
        CMD_STOP  = 2'b11
    } cmd_e;

    localparam logic [2:0] ADDR_DIV0 = 3'd0;
    localparam logic [2:0] ADDR_DIV1 = 3'd1;
    localparam logic [2:0] ADDR_DIV2 = 3'd2;
    localparam logic [2:0] ADDR_DIV3 = 3'd3;
    localparam logic [2:0] ADDR_MASK = 3'd4;

    function automatic logic is_div_addr(input logic [2:0] addr);
        return addr <= ADDR_DIV3;
    endfunction

endpackage

// File: rtl/tick_sched_chan.sv
// One scheduler channel: phase counter, active/shadow divisor with pending flag, registered tick strobe.
module tick_sched_chan #(
    parameter int            CW      = 21,
    parameter logic [CW-1:0] DIV_RST = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
    input  logic          i_en,
    input  logic          i_idle_apply,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wdata,
    output logic          o_tick,
    output logic          o_pending
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_shadow;
    logic          r_pending;
    logic          r_tick;

    logic w_live;
    logic w_hit;
    logic w_apply;

    assign w_live  = i_run && i_en;
    // >= rather than == so a divisor lowered while paused cannot let cnt run past it
    assign w_hit   = w_live && (r_cnt >= r_div);
    assign w_apply = w_hit || !w_live || i_idle_apply;

    // NOTE: all state updates use <= so every flop samples pre-edge values together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_div     <= DIV_RST;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_hit;

            if (i_idle_apply || !i_en) begin
                r_cnt <= '0;
            end else if (w_hit) begin
                r_cnt <= '0;
            end else if (w_live) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (i_wr && i_idle_apply) begin
                r_div     <= i_wdata;
                r_pending <= 1'b0;
            end else if (i_wr) begin
                r_pending <= 1'b1;
            end else if (r_pending && w_apply) begin
                r_div     <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    // NOTE: shadow has no reset; it is only read while r_pending is set.
    always_ff @(posedge i_clk) begin
        if (i_wr && !i_idle_apply) begin
            r_shadow <= i_wdata;
        end
    end

    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

// File: rtl/tick_sched.sv
// Four-channel tick-strobe scheduler with IDLE/RUN/PAUSE control and config port.
// Define TICK_SCHED_SQUARE_EN to add the o_sq divided-clock view outputs.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int CW       = 21,
    parameter int DIV0_RST = 3,
    parameter int DIV1_RST = 524287,
    parameter int DIV2_RST = 65535,
    parameter int DIV3_RST = 65535
) (
    input  logic              i_mclk,
    input  logic              i_clr,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [2:0]        i_cfg_addr,
    input  logic [CW-1:0]     i_cfg_data,
    output logic [NUM_CH-1:0] o_tick,
    output logic [1:0]        o_state
`ifdef TICK_SCHED_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] o_sq
`endif
);

    localparam logic [NUM_CH-1:0][CW-1:0] DIV_RST_ALL = {
        CW'(DIV3_RST), CW'(DIV2_RST), CW'(DIV1_RST), CW'(DIV0_RST)
    };

    logic [1:0]        r_state;
    logic [NUM_CH-1:0] r_mask;

    logic [1:0]        w_state_nxt;
    logic              w_stop;
    logic              w_run;
    logic              w_accept;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_tick;

    assign w_stop = i_cmd_valid && (cmd_e'(i_cmd) == CMD_STOP);
    assign w_run  = (r_state == ST_RUN);

    // NOTE: next-state defaults to current state first, so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (i_cmd_valid) begin
            case (cmd_e'(i_cmd))
                CMD_START: if (r_state != ST_RUN) w_state_nxt = ST_RUN;
                CMD_PAUSE: if (r_state == ST_RUN) w_state_nxt = ST_PAUSE;
                CMD_STOP:  w_state_nxt = ST_IDLE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_mclk) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only a divisor write to a channel still holding an unapplied value stalls.
    assign o_cfg_ready = !(is_div_addr(i_cfg_addr) && w_pending[i_cfg_addr[1:0]]);
    assign w_accept    = i_cfg_valid && o_cfg_ready;

    always_ff @(posedge i_mclk) begin
        if (i_clr) begin
            r_mask <= '1;
        end else if (w_accept && (i_cfg_addr == ADDR_MASK)) begin
            r_mask <= i_cfg_data[NUM_CH-1:0];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_wr[g] = w_accept && (i_cfg_addr == 3'(g));

        tick_sched_chan #(
            .CW      (CW),
            .DIV_RST (DIV_RST_ALL[g])
        ) u_chan (
            .i_clk        (i_mclk),
            .i_rst        (i_clr),
            .i_run        (w_run),
            .i_en         (r_mask[g]),
            .i_idle_apply (w_stop),
            .i_wr         (w_wr[g]),
            .i_wdata      (i_cfg_data),
            .o_tick       (w_tick[g]),
            .o_pending    (w_pending[g])
        );
    end

    assign o_tick  = w_tick;
    assign o_state = r_state;

`ifdef TICK_SCHED_SQUARE_EN
    logic [NUM_CH-1:0] r_sq;

    // A straggler tick landing in IDLE must not leave sq set after a stop.
    always_ff @(posedge i_mclk) begin
        if (i_clr || w_stop) begin
            r_sq <= '0;
        end else if (r_state != ST_IDLE) begin
            r_sq <= r_sq ^ w_tick;
        end
    end

    assign o_sq = r_sq;
`endif

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: per-cycle scoreboard plus timing checks derived from the tick rules.
module tb_tick_sched;

    localparam int         CW       = 21;
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSE  = 2'b10;
    localparam logic [1:0] C_START  = 2'b01;
    localparam logic [1:0] C_PAUSE  = 2'b10;
    localparam logic [1:0] C_STOP   = 2'b11;
    localparam logic [2:0] A_MASK   = 3'd4;

    logic          i_mclk = 1'b0;
    logic          i_clr = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic [1:0]    i_cmd = 2'b00;
    logic          i_cfg_valid = 1'b0;
    logic          o_cfg_ready;
    logic [2:0]    i_cfg_addr = 3'd0;
    logic [CW-1:0] i_cfg_data = '0;
    logic [3:0]    o_tick;
    logic [1:0]    o_state;
`ifdef TICK_SCHED_SQUARE_EN
    logic [3:0]    o_sq;
`endif

    tick_sched dut (
        .i_mclk      (i_mclk),
        .i_clr       (i_clr),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_data  (i_cfg_data),
        .o_tick      (o_tick),
        .o_state     (o_state)
`ifdef TICK_SCHED_SQUARE_EN
        ,
        .o_sq        (o_sq)
`endif
    );

    always #5 i_mclk = ~i_mclk;

    typedef struct {
        logic [3:0] tick;
        logic [1:0] state;
        logic [3:0] sq;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state
    logic [1:0] m_state;
    int         m_cnt  [4];
    int         m_div  [4];
    int         m_sh   [4];
    bit         m_pend [4];
    logic [3:0] m_mask;
    logic [3:0] m_tick;
    logic [3:0] m_sq;
    bit         m_init = 1'b0;
    int         div_rst [4] = '{3, 524287, 65535, 65535};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_state = S_IDLE;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = div_rst[i];
            m_sh[i]   = 0;
            m_pend[i] = 1'b0;
        end
        m_mask = 4'b1111;
        m_tick = 4'b0000;
        m_sq   = 4'b0000;
    endfunction

    // Drive one cycle of stimulus, predict the post-edge outputs, then score them.
    task automatic step(input bit clr, input bit cv, input logic [1:0] c, input bit fv,
                        input logic [2:0] a, input int d, output logic rdy);
        exp_t e, o;
        logic m_rdy, acc, stop, run, en, hit, wr;
        logic [3:0] n_tick;
        logic [1:0] n_state;
        i_clr = clr; i_cmd_valid = cv; i_cmd = c;
        i_cfg_valid = fv; i_cfg_addr = a; i_cfg_data = CW'(d);
        #1;
        rdy   = o_cfg_ready;
        m_rdy = !((a < 3'd4) && m_pend[a[1:0]]);
        if (m_init) check("cfg_ready", {31'b0, rdy}, {31'b0, m_rdy});
        if (clr) begin
            model_reset();
        end else begin
            acc  = fv && m_rdy;
            stop = cv && (c == C_STOP);
            run  = (m_state == S_RUN);
            if (stop) m_sq = 4'b0000;
            else if (m_state != S_IDLE) m_sq = m_sq ^ m_tick;
            for (int i = 0; i < 4; i++) begin
                en        = m_mask[i];
                hit       = run && en && (m_cnt[i] >= m_div[i]);
                n_tick[i] = hit;
                wr        = acc && (a == 3'(i));
                if (stop || !en) m_cnt[i] = 0;
                else if (hit)    m_cnt[i] = 0;
                else if (run)    m_cnt[i] = m_cnt[i] + 1;
                if (wr && stop) begin
                    m_div[i] = d; m_pend[i] = 1'b0;
                end else if (wr) begin
                    m_sh[i] = d; m_pend[i] = 1'b1;
                end else if (m_pend[i] && (hit || !(run && en) || stop)) begin
                    m_div[i] = m_sh[i]; m_pend[i] = 1'b0;
                end
            end
            m_tick  = n_tick;
            n_state = m_state;
            if (cv) begin
                case (c)
                    C_START: if (m_state != S_RUN) n_state = S_RUN;
                    C_PAUSE: if (m_state == S_RUN) n_state = S_PAUSE;
                    C_STOP:  n_state = S_IDLE;
                    default: n_state = m_state;
                endcase
            end
            m_state = n_state;
            if (acc && (a == A_MASK)) m_mask = CW'(d) & 4'hF;
        end
        e.tick = m_tick; e.state = m_state; e.sq = m_sq;
        sb_q.push_back(e);
        @(posedge i_mclk);
        cyc++;
        @(negedge i_mclk);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            o = sb_q.pop_front();
            check("tick", {28'b0, o_tick}, {28'b0, o.tick});
            check("state", {30'b0, o_state}, {30'b0, o.state});
`ifdef TICK_SCHED_SQUARE_EN
            check("sq", {28'b0, o_sq}, {28'b0, o.sq});
`endif
        end
    endtask

    logic rdy;

    task automatic nop(input int n);
        logic r;
        for (int k = 0; k < n; k++) step(0, 0, 2'b00, 0, 3'd0, 0, r);
    endtask

    task automatic send_cmd(input logic [1:0] c);
        logic r;
        step(0, 1, c, 0, 3'd0, 0, r);
    endtask

    task automatic cfg_wr(input logic [2:0] a, input int d, output logic r);
        step(0, 0, 2'b00, 1, a, d, r);
    endtask

    // Step until channel ch ticks; timestamp is the cycle in which the strobe is high.
    task automatic wait_tick(input int ch, input int limit, output int at);
        logic r;
        at = -1;
        for (int k = 0; k < limit; k++) begin
            step(0, 0, 2'b00, 0, 3'd0, 0, r);
            if (o_tick[ch]) begin
                at = cyc;
                break;
            end
        end
        check($sformatf("wait_tick%0d_timeout", ch), {31'b0, at < 0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, at, p0, p1, p2, n, n0, r1, r2;
        logic prev;
        bit cv, fv;
        logic [1:0] c;
        logic [2:0] a;
        int d;

        // Reset
        model_reset();
        step(1, 0, 2'b00, 0, 3'd0, 0, rdy);
        m_init = 1'b1;
        step(1, 0, 2'b00, 0, 3'd0, 0, rdy);
        check("rst_state", {30'b0, o_state}, {30'b0, S_IDLE});
        check("rst_tick", {28'b0, o_tick}, 32'd0);
        check("rst_ready", {31'b0, o_cfg_ready}, 32'd1);

        // Test 1: start with ch0 div=3; ch2/ch3 shortened while idle
        cfg_wr(3'd2, 4, rdy);
        check("idle_wr_ready", {31'b0, rdy}, 32'd1);
        cfg_wr(3'd3, 6, rdy);
        nop(2);
        t = cyc;
        send_cmd(C_START);
        wait_tick(0, 20, at); check("t1_first_tick", at - t, 5);
        wait_tick(0, 20, at); check("t1_second_tick", at - t, 9);
        wait_tick(0, 20, at); check("t1_third_tick", at - t, 13);

        // Test 2: mid-period divisor write on ch2, then a stalled second write
        wait_tick(2, 20, p0);
        nop(1);
        cfg_wr(3'd2, 9, rdy);
        check("t2_wr_ready", {31'b0, rdy}, 32'd1);
        cfg_wr(3'd2, 7, rdy);
        check("t2_busy_ready", {31'b0, rdy}, 32'd0);
        wait_tick(2, 20, p1); check("t2_old_period", p1 - p0, 5);
        wait_tick(2, 20, p2); check("t2_new_period", p2 - p1, 10);

        // Test 3: ch0 div=5, pause with cnt held at 2, resume
        cfg_wr(3'd0, 5, rdy);
        wait_tick(0, 20, at);
        wait_tick(0, 20, at);
        nop(1);
        send_cmd(C_PAUSE);
        check("t3_paused_state", {30'b0, o_state}, {30'b0, S_PAUSE});
        n = 0;
        repeat (20) begin
            nop(1);
            if (o_tick[0]) n++;
        end
        check("t3_paused_ticks", n, 0);
        t = cyc;
        send_cmd(C_START);
        wait_tick(0, 20, at); check("t3_resume_tick", at - t, 5);

        // Test 4: pending ch3 write applied by stop; stop with simultaneous ch2 write
        cfg_wr(3'd3, 2, rdy);
        step(0, 1, C_STOP, 1, 3'd2, 3, rdy);
        check("t4_stop_wr_ready", {31'b0, rdy}, 32'd1);
        nop(1);
        t = cyc;
        send_cmd(C_START);
        wait_tick(3, 20, at); check("t4_ch3_first", at - t, 4);
        wait_tick(2, 20, at); check("t4_ch2_first", at - t, 5);
        wait_tick(0, 20, at); check("t4_ch0_first", at - t, 7);

        // Test 5: mask down to ch0, then re-enable ch3
        cfg_wr(A_MASK, 1, rdy);
        nop(2);
        n = 0; n0 = 0;
        repeat (30) begin
            nop(1);
            if (o_tick[3:1] != 3'b000) n++;
            if (o_tick[0]) n0++;
        end
        check("t5_masked_ticks", n, 0);
        check("t5_ch0_ticks", n0, 5);
        t = cyc;
        cfg_wr(A_MASK, 9, rdy);
        wait_tick(3, 20, at); check("t5_ch3_reenable", at - t, 4);

        // Test 6: ch0 div=3 from a clean start, square view, then clr mid-run
        send_cmd(C_STOP);
        cfg_wr(3'd0, 3, rdy);
        nop(1);
        t = cyc;
        send_cmd(C_START);
`ifdef TICK_SCHED_SQUARE_EN
        r1 = -1; r2 = -1;
        prev = o_sq[0];
        for (int k = 0; k < 40 && r2 < 0; k++) begin
            nop(1);
            if (o_sq[0] && !prev) begin
                if (r1 < 0) r1 = cyc;
                else        r2 = cyc;
            end
            prev = o_sq[0];
        end
        check("t6_sq_first_rise", r1 - t, 6);
        check("t6_sq_period", r2 - r1, 8);
`endif
        wait_tick(0, 20, at);
        cfg_wr(3'd0, 6, rdy);
        nop(2);
        step(1, 0, 2'b00, 0, 3'd0, 0, rdy);
        check("t6_clr_tick", {28'b0, o_tick}, 32'd0);
        check("t6_clr_state", {30'b0, o_state}, {30'b0, S_IDLE});
`ifdef TICK_SCHED_SQUARE_EN
        check("t6_clr_sq", {28'b0, o_sq}, 32'd0);
`endif
        step(0, 0, 2'b00, 0, 3'd0, 0, rdy);
        check("t6_clr_pending_dropped", {31'b0, rdy}, 32'd1);

        // Randomised traffic through the scoreboard, small divisors including 0
        send_cmd(C_START);
        repeat (300) begin
            cv = ($urandom_range(0, 7) == 0);
            c  = 2'($urandom_range(0, 3));
            fv = ($urandom_range(0, 2) == 0);
            a  = 3'($urandom_range(0, 5));
            d  = (a == A_MASK) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
            step(0, cv, c, fv, a, d, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
